// File: rtl/drum_memory.sv
// rtl/drum_memory.sv - rotating-drum memory responder with sector-synchronous access
module drum_memory #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 31,
    parameter int SECTOR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_read_pulse,
    input  logic              mem_write_pulse,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_reply,
    output logic              mem_busy,
    output logic [ADDR_W-1:0] drum_pos
);

    localparam int SUB_W = (SECTOR_CYCLES > 1) ? $clog2(SECTOR_CYCLES) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SECTOR_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEEK  = 2'd1;
    localparam logic [1:0] ST_REPLY = 2'd2;

    // Word store: deliberately not reset so contents survive a reset pulse.
    logic [DATA_W-1:0] store_q [2**ADDR_W];

    logic [SUB_W-1:0]  sub_cnt_q, sub_cnt_d;
    logic [ADDR_W-1:0] drum_pos_q, drum_pos_d;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_write_q, is_write_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              sub_wrap;
    logic              hit;

    // Drum rotation: sub-sector counter, sector advances on its wrap.
    always_comb begin
        sub_wrap   = (sub_cnt_q == SUB_LAST);
        sub_cnt_d  = sub_wrap ? '0 : sub_cnt_q + 1'b1;
        drum_pos_d = sub_wrap ? drum_pos_q + 1'b1 : drum_pos_q;
    end

    // The head is over the requested word at the start of its sector.
    assign hit = (state_q == ST_SEEK) && (drum_pos_q == addr_q) && (sub_cnt_q == '0);

    // Request capture and IDLE -> SEEK -> REPLY sequencing; write beats read.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        rdata_d    = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_write_pulse) begin
                    addr_d     = mem_addr;
                    wdata_d    = mem_wdata;
                    is_write_d = 1'b1;
                    state_d    = ST_SEEK;
                end else if (mem_read_pulse) begin
                    addr_d     = mem_addr;
                    is_write_d = 1'b0;
                    state_d    = ST_SEEK;
                end
            end
            ST_SEEK: begin
                if (hit) begin
                    state_d = ST_REPLY;
                    if (!is_write_q) begin
                        rdata_d = store_q[addr_q];
                    end
                end
            end
            ST_REPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, captured request and drum position registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sub_cnt_q  <= '0;
            drum_pos_q <= '0;
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            sub_cnt_q  <= sub_cnt_d;
            drum_pos_q <= drum_pos_d;
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
        end
    end

    // Array write when the head reaches the target of a pending write.
    always_ff @(posedge clk) begin
        if (hit && is_write_q) begin
            store_q[addr_q] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_reply = (state_q == ST_REPLY);
    assign mem_busy  = (state_q != ST_IDLE);
    assign drum_pos  = drum_pos_q;

endmodule

// File: tb/tb_drum_memory.sv
// tb/tb_drum_memory.sv - scoreboard bench for drum_memory
module tb_drum_memory;

    localparam int AW     = 3;
    localparam int DW     = 31;
    localparam int SC     = 2;
    localparam int PERIOD = (2**AW) * SC;

    logic          clk = 1'b0;
    logic          resetn;
    logic          rd, wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          reply, busy;
    logic [AW-1:0] pos;

    drum_memory #(.ADDR_W(AW), .DATA_W(DW), .SECTOR_CYCLES(SC)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .mem_read_pulse  (rd),
        .mem_write_pulse (wr),
        .mem_addr        (addr),
        .mem_wdata       (wdata),
        .mem_rdata       (rdata),
        .mem_reply       (reply),
        .mem_busy        (busy),
        .drum_pos        (pos)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; equals the drum phase count.
    int cyc;
    always @(posedge clk) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    typedef struct {
        int            issue;
        int            reply;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_mem [2**AW];
    logic [DW-1:0] last_rd;
    int            n_checks = 0;
    int            n_pass   = 0;
    bit            skip_busy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: drum position, busy window, and reply/data against the scoreboard.
    exp_t e;
    bit   eb;
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            check("drum_pos", 64'(pos), 64'((cyc / SC) % (2**AW)));
            if (sb.size() > 0) eb = (cyc > sb[0].issue) && (cyc <= sb[0].reply);
            else               eb = 1'b0;
            if (!skip_busy) check("mem_busy", 64'(busy), 64'(eb));
            if (reply) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_reply: got reply at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("reply_cycle", 64'(cyc), 64'(e.reply));
                    check("mem_rdata", 64'(rdata), 64'(e.data));
                end
            end
        end
    end

    task automatic goto_phase(input int p);
        int n = 0;
        while ((cyc % PERIOD) != p && n < 64) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic start_req(input bit r, input bit w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int lat);
        exp_t x;
        x.issue = cyc;
        x.reply = cyc + lat;
        if (w) begin
            model_mem[a] = d;
        end else begin
            last_rd = model_mem[a];
        end
        x.data = last_rd;
        sb.push_back(x);
        rd = r; wr = w; addr = a; wdata = d;
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else begin
            $display("FAIL reply_timeout: %0d outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic req(input int p, input bit r, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int lat);
        goto_phase(p);
        start_req(r, w, a, d, lat);
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_reply"}, 64'(reply), 64'(0));
        check({tag, "_busy"},  64'(busy),  64'(0));
        check({tag, "_rdata"}, 64'(rdata), 64'(0));
        check({tag, "_pos"},   64'(pos),   64'(0));
    endtask

    initial begin
        rd = 0; wr = 0; addr = '0; wdata = '0; skip_busy = 0; last_rd = '0;
        resetn = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Latencies below are hand-derived from the issue phase and 2*addr.
        req(0, 0, 1, 3'd0, 31'h0AAAAAA, 17);
        req(0, 0, 1, 3'd3, 31'h0000ABC, 7);
        req(0, 1, 0, 3'd3, '0, 7);
        req(0, 0, 1, 3'd5, 31'h1234567, 11);
        req(0, 1, 0, 3'd5, '0, 11);
        req(5, 1, 0, 3'd3, '0, 2);
        req(8, 0, 1, 3'd4, 31'h0004444, 17);
        req(0, 1, 1, 3'd2, 31'h0000055, 5);
        req(0, 1, 0, 3'd2, '0, 5);

        // Second read pulsed during SEEK must be ignored.
        goto_phase(0);
        start_req(1, 0, 3'd5, '0, 11);
        @(posedge clk); #1;
        rd = 1'b1; addr = 3'd2;
        @(posedge clk); #1;
        rd = 1'b0;
        wait_done();

        // Reset in the middle of a write to addr 6 aborts it.
        req(0, 0, 1, 3'd6, 31'h0606060, 13);
        goto_phase(0);
        skip_busy = 1;
        wr = 1'b1; addr = 3'd6; wdata = 31'h7777777;
        @(posedge clk); #1;
        wr = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("busy_mid_seek", 64'(busy), 64'(1));
        resetn = 1'b0; last_rd = '0;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        resetn = 1'b1;
        skip_busy = 0;

        req(0, 1, 0, 3'd0, '0, 17);
        req(0, 1, 0, 3'd6, '0, 13);
        req(0, 1, 0, 3'd4, '0, 9);

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
